// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
// Shared constants for the SPI RAM controller: default widths, the 2-bit
// command codes carried in rx_data[9:8], and the controller FSM encodings.
// -----------------------------------------------------------------------------
package spi_ram_pkg;

  localparam int ADDR_SIZE_D = 8;
  localparam int DATA_W_D    = 8;
  localparam int MEM_DEPTH_D = 2 ** ADDR_SIZE_D;

  // Command field of an rx word
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Controller FSM
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl_if
// Bus bundle between the controller and its two agents.
//   SPI side : rx_data/rx_valid (command in), tx_data/tx_valid (read data out)
//   Host side: host_req/we/addr/wdata in, host_gnt/rvalid/rdata out
//   Status   : spi_ovf (sticky dropped-command flag)
// Modports: slave = controller view, master = agent/bench view.
// -----------------------------------------------------------------------------
interface spi_ram_ctrl_if
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_D,
  parameter int DATA_W    = DATA_W_D
);

  logic [DATA_W+1:0]    rx_data;
  logic                 rx_valid;
  logic [DATA_W-1:0]    tx_data;
  logic                 tx_valid;
  logic                 host_req;
  logic                 host_we;
  logic [ADDR_SIZE-1:0] host_addr;
  logic [DATA_W-1:0]    host_wdata;
  logic                 host_gnt;
  logic                 host_rvalid;
  logic [DATA_W-1:0]    host_rdata;
  logic                 spi_ovf;

  modport slave (
    input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata,
    output tx_data, tx_valid, host_gnt, host_rvalid, host_rdata, spi_ovf
  );

  modport master (
    output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata,
    input  tx_data, tx_valid, host_gnt, host_rvalid, host_rdata, spi_ovf
  );

endinterface

// File: rtl/spi_ram_mem.sv
// -----------------------------------------------------------------------------
// spi_ram_mem
// Single-port synchronous RAM, read-first, one cycle read latency.
//   clk     : clock
//   i_we    : write enable for i_addr/i_din
//   i_addr  : word address
//   i_din   : write data
//   o_dout  : registered read data of the address presented last cycle
// -----------------------------------------------------------------------------
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int MEM_DEPTH = 2 ** ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [DATA_W-1:0]    i_din,
  output logic [DATA_W-1:0]    o_dout
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  // NOTE: the array has no reset on purpose -- RAM macros cannot clear their
  // contents, and data must survive an rst_n pulse.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_din;
    o_dout <= r_mem[i_addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
// Decodes SPI command words into RAM writes/reads and shares the RAM with a
// parallel host port through a two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : spi_ram_ctrl_if.slave -- SPI rx/tx, host request/response,
//                sticky spi_ovf
// One SPI memory command (01/11) can be outstanding; a second one arriving
// while it is still pending is dropped and flagged on spi_ovf.
// -----------------------------------------------------------------------------
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int MEM_DEPTH = 2 ** ADDR_SIZE
) (
  input logic           clk,
  input logic           rst_n,
  spi_ram_ctrl_if.slave bus
);

  // Capture path
  logic                 r_rx_valid_q;
  logic                 w_capture;
  logic [1:0]           w_cmd;
  logic [DATA_W-1:0]    w_payload;

  // Address registers and the single pending SPI access
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_spi_pend;
  logic                 r_spi_we;
  logic [ADDR_SIZE-1:0] r_spi_addr;
  logic [DATA_W-1:0]    r_spi_data;

  // Arbiter / FSM
  logic [0:0]           r_state;
  logic                 r_last_spi;
  logic                 r_owner_spi;
  logic                 w_spi_win;
  logic                 w_host_win;

  // Outputs
  logic [DATA_W-1:0]    r_tx_data;
  logic                 r_tx_valid;
  logic [DATA_W-1:0]    r_host_rdata;
  logic                 r_host_rvalid;
  logic                 r_spi_ovf;

  // RAM port
  logic                 w_mem_we;
  logic [ADDR_SIZE-1:0] w_mem_addr;
  logic [DATA_W-1:0]    w_mem_din;
  logic [DATA_W-1:0]    w_mem_dout;

  assign w_capture = bus.rx_valid & ~r_rx_valid_q;
  assign w_cmd     = bus.rx_data[DATA_W+1:DATA_W];
  assign w_payload = bus.rx_data[DATA_W-1:0];

  // Round robin: on contention the requester that did not win last goes.
  assign w_spi_win  = (r_state == IDLE) & r_spi_pend & (~bus.host_req | ~r_last_spi);
  assign w_host_win = (r_state == IDLE) & bus.host_req & (~r_spi_pend | r_last_spi);

  // NOTE: every output of this block gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = r_spi_addr;
    w_mem_din  = r_spi_data;
    if (w_host_win) begin
      w_mem_we   = bus.host_we;
      w_mem_addr = bus.host_addr;
      w_mem_din  = bus.host_wdata;
    end else if (w_spi_win) begin
      w_mem_we   = r_spi_we;
    end
  end

  spi_ram_mem #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_mem_we),
    .i_addr (w_mem_addr),
    .i_din  (w_mem_din),
    .o_dout (w_mem_dout)
  );

  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees pre-edge values; a later assignment to the same register wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_valid_q  <= 1'b0;
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_spi_pend    <= 1'b0;
      r_spi_we      <= 1'b0;
      r_spi_addr    <= '0;
      r_spi_data    <= '0;
      r_state       <= IDLE;
      r_last_spi    <= 1'b0;
      r_owner_spi   <= 1'b0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
      r_spi_ovf     <= 1'b0;
    end else begin
      r_rx_valid_q  <= bus.rx_valid;
      r_host_rvalid <= 1'b0;

      // Capture acts on the pre-edge pending flag, so a command is never
      // arbitrated in its own capture cycle.
      if (w_capture) begin
        r_tx_valid <= 1'b0;
        case (w_cmd)
          CMD_WR_ADDR: r_wr_addr <= w_payload[ADDR_SIZE-1:0];
          CMD_RD_ADDR: r_rd_addr <= w_payload[ADDR_SIZE-1:0];
          default: begin
            if (r_spi_pend) begin
              r_spi_ovf <= 1'b1;
            end else begin
              r_spi_pend <= 1'b1;
              r_spi_we   <= (w_cmd == CMD_WR_DATA);
              r_spi_addr <= (w_cmd == CMD_WR_DATA) ? r_wr_addr : r_rd_addr;
              r_spi_data <= w_payload;
            end
          end
        endcase
      end

      // A read completing on a capture edge still reports its data.
      case (r_state)
        IDLE: begin
          if (w_spi_win) begin
            r_last_spi <= 1'b1;
            if (r_spi_we) begin
              r_spi_pend <= 1'b0;
            end else begin
              r_state     <= RD_WAIT;
              r_owner_spi <= 1'b1;
            end
          end else if (w_host_win) begin
            r_last_spi <= 1'b0;
            if (!bus.host_we) begin
              r_state     <= RD_WAIT;
              r_owner_spi <= 1'b0;
            end
          end
        end
        RD_WAIT: begin
          if (r_owner_spi) begin
            r_tx_data  <= w_mem_dout;
            r_tx_valid <= 1'b1;
            r_spi_pend <= 1'b0;
          end else begin
            r_host_rdata  <= w_mem_dout;
            r_host_rvalid <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.tx_data     = r_tx_data;
  assign bus.tx_valid    = r_tx_valid;
  assign bus.host_gnt    = w_host_win;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.spi_ovf     = r_spi_ovf;

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Memory controller behind the SPI slave. It decodes the 10-bit command words the slave presents on rx_data/rx_valid. It keeps separate write and read address registers and performs accesses on a single-port 256x8 RAM. Read data goes back to the slave on tx_data/tx_valid. A second, parallel host port shares the same RAM through a round-robin arbiter, so a local agent can preload or inspect memory while SPI traffic runs.

Parameters:
MEM_DEPTH, 256, number of RAM words
ADDR_SIZE, 8, address width; MEM_DEPTH = 2**ADDR_SIZE
DATA_W, 8, RAM word width; rx_data width is DATA_W+2

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
rx_data  in  DATA_W+2  command word from slave; [9:8]=cmd, [7:0]=payload
rx_valid  in  1  level from slave; stays high while rx_data is held
tx_data  out  DATA_W  read data to slave
tx_valid  out  1  tx_data valid (level)
host_req  in  1  host access request; hold with fields until host_gnt
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_SIZE  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  combinational, 1-cycle accept of host request
host_rvalid  out  1  1-cycle pulse, host_rdata valid
host_rdata  out  DATA_W  host read data, held until next host read
spi_ovf  out  1  sticky: an SPI memory command was dropped

Behaviour:
- Reset (async, rst_n=0) clears the following: tx_data=0, tx_valid=0, host_rvalid=0, host_rdata=0, spi_ovf=0, wr_addr=0, rd_addr=0, spi_pend=0, last_spi=0, state=IDLE. RAM contents are not reset. Reset mid-access aborts the access. Any pending SPI command is lost.
- Capture: a command is taken only on the rising edge of rx_valid, detected with a registered rx_valid_q (rx_valid=1 and rx_valid_q=0). A held rx_valid never re-triggers. tx_valid clears on every capture edge.
- Cmd 2'b00: wr_addr <= payload at the capture edge. No RAM access.
- Cmd 2'b10: rd_addr <= payload at the capture edge. No RAM access.
- Cmd 2'b01 (write data): when spi_pend=0, sets spi_pend=1 and latches {we=1, addr=wr_addr, data=payload}.
- Cmd 2'b11 (read data): when spi_pend=0, sets spi_pend=1 and latches {we=0, addr=rd_addr}. The payload is ignored.
- If spi_pend=1 at a 01/11 capture, the new command is dropped and spi_ovf <= 1. Commands 00/10 are never dropped.
- FSM states: IDLE, RD_WAIT.
  - IDLE, one requester only: grant it.
  - IDLE, both spi_pend and host_req: grant SPI if last_spi=0, else host.
  - Each grant updates last_spi (1 = SPI won).
  - Granted write: RAM written at that edge; stay IDLE; spi_pend or host handshake completes.
  - Granted read: RAM read issued at that edge; go to RD_WAIT and remember the owner.
  - RD_WAIT: the synchronous RAM output is valid. If the owner is SPI: tx_data <= dout, tx_valid <= 1, spi_pend <= 0. If the owner is host: host_rdata <= dout, host_rvalid <= 1 for one cycle. Always return to IDLE.
- host_gnt is asserted only in IDLE when the host wins; host_req is ignored in RD_WAIT.
- A capture and a grant in the same cycle: the capture acts on pre-edge spi_pend. A new SPI command is therefore arbitrated the cycle after capture at the earliest.
- Uncontended SPI read latency: edge E0 samples the rx_valid rise; E1 grants and reads; tx_valid=1 after E2.
- Uncontended host read: host_gnt in the cycle before edge E1; host_rvalid is high in the cycle after E2.
- A host write and an SPI read to the same address, granted write first: the read returns the new data. No bypass is needed because the accesses are serialized.

Decomposition:
- Package spi_ram_pkg holds:
  - command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
  - FSM state encodings IDLE/RD_WAIT
  - default widths
- One sub-module, spi_ram_mem: single-port synchronous RAM with inputs we, addr, din and registered output dout, 1-cycle read latency.

Test Plan:
- SPI write: rx_data=10'h03A rising, then 10'h1C5 rising. Required: RAM[0x3A]=0xC5 two edges after the second capture; tx_valid stays 0.
- SPI read: continuing the SPI write test, send 10'h23A then 10'h300. Required: tx_data=0xC5, tx_valid=1 after the 3rd edge from the rise; both held until the next rx_valid rise clears tx_valid.
- Contention after reset: an SPI write pend (addr 0x3A, data 0x11) and host read 0x3A request in the same IDLE cycle. Required: SPI granted first (host_gnt=0), host_gnt the next cycle, host_rdata=0x11 with a 1-cycle host_rvalid.
- Repeated contention: host_req held high with back-to-back SPI reads. Required: grants alternate SPI/host/SPI; neither requester waits more than one grant.
- Held rx_valid plus overflow: rx_valid high for 20 cycles gives exactly one capture. A second 01 rise while spi_pend=1 (host hogging, pend forced) leads to a dropped command and spi_ovf=1 until reset.
- Reset mid-read: rst_n=0 during RD_WAIT. Required: immediate tx_valid=0, host_rvalid=0, spi_pend=0, state IDLE; RAM contents written earlier are still readable after release.
